dmem_cam_responder: RTL
=======================

// Module: dmem_cam_responder
// PURPOSE
//  Data-memory responder at the far end of the CPU data port: serves loads/stores issued by the pipelined core
//  (WriteAddress/WriteData/write_enable in, ReadData out). Holds a word RAM plus a memory-mapped camera window:
//  camera bytes are packed into 32-bit words and buffered in a FIFO that software drains through MMIO registers.
// PARAMETERS
//  RAM_WORDS   64            words of data RAM, mapped at byte address 0 .. RAM_WORDS*4-1
//  MMIO_BASE   32'h0000_0400 byte base of camera registers; must be >= RAM_WORDS*4
//  FIFO_DEPTH  16            pixel-word FIFO entries; power of 2, 2..128
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  reset         in   1   synchronous, active-low reset (0 = reset)
//  WriteAddress  in   32  byte address from core memory stage; bits [1:0] ignored
//  WriteData     in   32  store data
//  write_enable  in   1   store strobe, sampled on rising edge
//  ReadData      out  32  load data, combinational from WriteAddress
//  pix_valid     in   1   camera byte valid this cycle; no backpressure
//  pix_data      in   8   camera byte
//  frame_start   in   1   one-cycle pulse at start of a frame
// BEHAVIOUR
//  Address map (word aligned): RAM if addr < RAM_WORDS*4, index addr[..:2]. MMIO_BASE+0 CAM_DATA (R),
//   +4 CAM_STAT (R), +8 CAM_CTRL (W). Other addresses: read 0, write ignored.
//  Reads: 0-cycle combinational. RAM -> word at index; CAM_DATA -> FIFO head word (0 if empty, no pop);
//   CAM_STAT -> [0] empty, [1] full, [2] overflow, [15:8] count, [31:24] frame_cnt, other bits 0; CAM_CTRL reads 0.
//  Writes: on rising edge with write_enable=1 and reset=1. RAM word written in full (no byte lanes).
//   CAM_CTRL: bit0 pop (ignored if empty), bit1 flush (FIFO and packer cleared), bit2 clear overflow.
//   Bits may be combined in one write; writes to CAM_DATA/CAM_STAT ignored.
//  Reset (reset=0 at edge): FIFO pointers/count 0, packer byte_cnt 0, overflow 0, frame_cnt 0.
//   RAM contents not cleared. ReadData forced to 0 while reset=0.
//  Packer: byte_cnt 0..3; byte i lands in bits [8i+7:8i] (little-endian, first byte in [7:0]).
//   On 4th byte, word is pushed the same edge; byte_cnt wraps to 0. Push latency: word visible at CAM_DATA
//   the cycle after the edge accepting byte 3.
//  frame_start: partial word discarded, byte_cnt<=0, frame_cnt+=1 (8-bit, wraps 255->0). Same-cycle pix_valid
//   byte is taken as byte 0 of the new frame.
//  FIFO: count 0..FIFO_DEPTH, pointers wrap modulo FIFO_DEPTH.
//   Push when full with no pop: word dropped, overflow<=1 (sticky until CTRL bit2 or reset).
//   Push+pop same edge when full: both occur, count unchanged, no overflow.
//   Push+pop when empty: pop ignored, push succeeds, count=1.
//   Flush+push same edge: flush wins, FIFO empty, word dropped, overflow unchanged.
//   Clear-overflow and new overflow same edge: overflow ends at 1.
//  Reset asserted mid-frame or mid-word discards all buffered data; packer restarts at byte 0.
// TESTING
//  1 Store 32'hDEAD_BEEF to 0x10, load 0x10 and 0x13 -> both read 32'hDEAD_BEEF; load 0x800 -> 0.
//  2 Feed bytes 11,22,33,44 -> CAM_STAT count=1, empty=0; CAM_DATA=32'h4433_2211; CTRL=1 -> count=0, empty=1.
//  3 Feed 2 bytes, pulse frame_start, feed 55,66,77,88 -> one word 32'h8877_6655, frame_cnt=1.
//  4 Fill 16 words, push a 17th -> full=1, overflow=1, count=16, head unchanged; CTRL=4 -> overflow=0.
//  5 Full FIFO, write CTRL=1 on the edge accepting a word's 4th byte -> count stays 16, overflow=0.
//  6 Hold reset=0 one cycle with 3 words buffered and byte_cnt=2 -> ReadData=0 during reset; after release
//    count=0, next 4 bytes form a complete word; RAM word at 0x10 still 32'hDEAD_BEEF.

Source files
------------

// File: rtl/dmem_cam_responder.sv
// Data-memory responder: word RAM plus a memory-mapped camera window that packs
// incoming pixel bytes into 32-bit words and buffers them in a FIFO drained by software.
module dmem_cam_responder #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] WriteAddress,
    input  logic [31:0] WriteData,
    input  logic        write_enable,
    output logic [31:0] ReadData,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        frame_start
);

    localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW        = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [29:0] DATA_W    = MMIO_BASE[31:2];
    localparam logic [29:0] STAT_W    = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] CTRL_W    = MMIO_BASE[31:2] + 30'd2;

    logic [31:0]   r_ram  [RAM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [7:0]    r_frame_cnt;
    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_pack;

    logic [29:0]   w_word;
    logic          w_is_ram;
    logic [AW-1:0] w_ram_idx;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic [1:0]    w_bc;
    logic          w_push;
    logic [31:0]   w_push_word;
    logic          w_push_ok;
    logic          w_ovf_set;
    logic [1:0]    w_unused_addr_bits;

    assign w_unused_addr_bits = WriteAddress[1:0];
    assign w_word      = WriteAddress[31:2];
    assign w_is_ram    = WriteAddress < RAM_BYTES;
    assign w_ram_idx   = WriteAddress[AW+1:2];
    assign w_ctrl_wr   = write_enable && reset && (w_word == CTRL_W);
    assign w_flush     = w_ctrl_wr && WriteData[1];
    assign w_clr_ovf   = w_ctrl_wr && WriteData[2];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = w_ctrl_wr && WriteData[0] && !w_empty && !w_flush;

    // frame_start restarts the packer in the same cycle, so a concurrent byte is byte 0
    assign w_bc        = frame_start ? 2'd0 : r_byte_cnt;
    assign w_push      = pix_valid && (w_bc == 2'd3);
    assign w_push_word = {pix_data, r_pack};
    assign w_push_ok   = w_push && !w_flush && (!w_full || w_pop);
    assign w_ovf_set   = w_push && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset && write_enable && w_is_ram) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push_ok) begin
            r_fifo[r_wptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_byte_cnt  <= 2'd0;
            r_pack      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (frame_start) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_flush) begin
                r_byte_cnt <= 2'd0;
            end else if (pix_valid) begin
                case (w_bc)
                    2'd0:    r_pack[7:0]   <= pix_data;
                    2'd1:    r_pack[15:8]  <= pix_data;
                    2'd2:    r_pack[23:16] <= pix_data;
                    default: ;
                endcase
                r_byte_cnt <= w_bc + 2'd1;
            end else if (frame_start) begin
                r_byte_cnt <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push_ok) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                case ({w_push_ok, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
            // a new overflow beats a same-edge clear
            r_ovf <= w_ovf_set | (r_ovf & ~w_clr_ovf);
        end
    end

    always_comb begin
        ReadData = '0;
        if (reset) begin
            if (w_is_ram) begin
                ReadData = r_ram[w_ram_idx];
            end else if (w_word == DATA_W) begin
                ReadData = w_empty ? '0 : r_fifo[r_rptr];
            end else if (w_word == STAT_W) begin
                ReadData = {r_frame_cnt, 8'h00, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
            end
        end
    end

endmodule
